// File: rtl/apc32_accum_if.sv
// Beat-in / result-out handshake bundle for apc32_accum.
// master drives beats and accepts results; slave is the accumulator.
interface apc32_accum_if #(
    parameter int ACC_W = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_count;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_fire;
    logic             out_ovf;
    logic             out_err;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_sum,
        input  out_fire, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_sum,
        output out_fire, out_ovf, out_err
    );
endinterface

// File: rtl/apc32_accum.sv
// Windowed popcount accumulator with threshold fire (binarized neuron).
// Define APC_ACC_SAT_EN to saturate on overflow instead of wrapping.
module apc32_accum #(
    parameter int ACC_W     = 12,
    parameter int THRESH    = 256,
    parameter int MAX_BEATS = 16
) (
    input logic         clk,
    input logic         rst,
    apc32_accum_if.slave bus
);
    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [8:0]       LAST_BEAT = 9'(MAX_BEATS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX   = '1;
    localparam logic [31:0]      THR       = 32'(THRESH);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [8:0]       beat_cnt;
    logic             ovf;
    logic             err;
    logic [ACC_W-1:0] sum_q;
    logic             fire_q;
    logic             ovf_q;
    logic             err_q;

    logic             take;
    logic             bad;
    logic [5:0]       cnt;
    logic [ACC_W:0]   sum_w;
    logic             carry;
    logic [ACC_W-1:0] acc_nx;
    logic             close;
    logic             fire_nx;

    always_comb begin
        take  = bus.in_valid & (state == ACC);
        bad   = bus.in_count > 6'd32;
        cnt   = bad ? 6'd32 : bus.in_count;
        sum_w = {1'b0, acc} + {{(ACC_W-5){1'b0}}, cnt};
        carry = sum_w[ACC_W];
`ifdef APC_ACC_SAT_EN
        acc_nx = carry ? ACC_MAX : sum_w[ACC_W-1:0];
`else
        acc_nx = sum_w[ACC_W-1:0];
`endif
        close   = take & (bus.in_last | (beat_cnt == LAST_BEAT));
        fire_nx = {{(32-ACC_W){1'b0}}, acc_nx} >= THR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            sum_q    <= '0;
            fire_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (take) begin
                        acc      <= acc_nx;
                        beat_cnt <= beat_cnt + 9'd1;
                        ovf      <= ovf | carry;
                        err      <= err | bad;
                    end
                    if (close) begin
                        state  <= HOLD;
                        sum_q  <= acc_nx;
                        fire_q <= fire_nx;
                        ovf_q  <= ovf | carry;
                        err_q  <= err | bad;
                    end
                end
                HOLD: begin
                    // result registers keep their value until the next close
                    if (bus.out_ready) begin
                        state    <= ACC;
                        acc      <= '0;
                        beat_cnt <= '0;
                        ovf      <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_fire  = fire_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_apc32_accum.sv
// Directed bench for apc32_accum: default instance plus an 8-bit
// accumulator instance for overflow behaviour.
module tb_apc32_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apc32_accum_if #(.ACC_W(12)) a ();
    apc32_accum_if #(.ACC_W(8))  b ();

    apc32_accum #(.ACC_W(12), .THRESH(256), .MAX_BEATS(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    apc32_accum #(.ACC_W(8), .THRESH(256), .MAX_BEATS(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [5:0] c, input logic l);
        check("a_in_ready_before_beat", a.in_ready, 1);
        a.in_valid = 1'b1;
        a.in_count = c;
        a.in_last  = l;
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [5:0] c, input logic l);
        b.in_valid = 1'b1;
        b.in_count = c;
        b.in_last  = l;
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask

    task automatic release_a();
        a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        a.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a.in_valid = 0; a.in_count = 0; a.in_last = 0; a.out_ready = 0;
        b.in_valid = 0; b.in_count = 0; b.in_last = 0; b.out_ready = 0;

        #2;
        check("rst_in_ready", a.in_ready, 1);
        check("rst_out_valid", a.out_valid, 0);
        check("rst_out_sum", a.out_sum, 0);
        check("rst_out_fire", a.out_fire, 0);
        check("rst_out_ovf", a.out_ovf, 0);
        check("rst_out_err", a.out_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 10+20+30+32 with last, consumer always ready
        a.out_ready = 1'b1;
        send_a(6'd10, 1'b0);
        send_a(6'd20, 1'b0);
        send_a(6'd30, 1'b0);
        check("w1_no_early_valid", a.out_valid, 0);
        send_a(6'd32, 1'b1);
        check("w1_out_valid", a.out_valid, 1);
        check("w1_in_ready_low", a.in_ready, 0);
        check("w1_out_sum", a.out_sum, 92);
        check("w1_out_fire", a.out_fire, 0);
        check("w1_out_ovf", a.out_ovf, 0);
        check("w1_out_err", a.out_err, 0);
        @(posedge clk);
        #1;
        a.out_ready = 1'b0;
        check("w1_valid_drop", a.out_valid, 0);
        check("w1_in_ready_back", a.in_ready, 1);
        check("w1_sum_kept", a.out_sum, 92);

        // 16 x 32 forced close, 17th beat held off
        for (int i = 0; i < 15; i++) send_a(6'd32, 1'b0);
        check("w2_open_before_16", a.out_valid, 0);
        send_a(6'd32, 1'b0);
        check("w2_out_valid", a.out_valid, 1);
        check("w2_out_sum", a.out_sum, 512);
        check("w2_out_fire", a.out_fire, 1);
        a.in_valid = 1'b1;
        a.in_count = 6'd5;
        a.in_last  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("w2_hold_in_ready", a.in_ready, 0);
        check("w2_hold_sum", a.out_sum, 512);
        a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        a.out_ready = 1'b0;
        check("w2_bubble_valid", a.out_valid, 0);
        check("w2_bubble_ready", a.in_ready, 1);
        @(posedge clk);
        #1;
        a.in_valid = 1'b0;
        a.in_last  = 1'b0;
        check("w3_held_beat_valid", a.out_valid, 1);
        check("w3_held_beat_sum", a.out_sum, 5);
        check("w3_held_beat_fire", a.out_fire, 0);
        release_a();

        // result held 5 cycles with out_ready low
        send_a(6'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("w4_stall_valid", a.out_valid, 1);
            check("w4_stall_sum", a.out_sum, 7);
            check("w4_stall_in_ready", a.in_ready, 0);
            @(posedge clk);
            #1;
        end
        release_a();
        check("w4_after_valid", a.out_valid, 0);
        check("w4_after_ready", a.in_ready, 1);
        send_a(6'd3, 1'b1);
        check("w5_fresh_sum", a.out_sum, 3);
        release_a();

        // illegal count clamped and flagged
        send_a(6'd40, 1'b0);
        send_a(6'd5, 1'b1);
        check("w6_clamp_sum", a.out_sum, 37);
        check("w6_err", a.out_err, 1);
        check("w6_fire", a.out_fire, 0);
        release_a();
        send_a(6'd1, 1'b1);
        check("w7_err_cleared", a.out_err, 0);
        check("w7_sum", a.out_sum, 1);
        release_a();

        // 8-bit accumulator: 9 x 32 = 288
        for (int i = 0; i < 8; i++) send_b(6'd32, 1'b0);
        send_b(6'd32, 1'b1);
        check("b_out_valid", b.out_valid, 1);
`ifdef APC_ACC_SAT_EN
        check("b_sat_sum", b.out_sum, 255);
`else
        check("b_wrap_sum", b.out_sum, 32);
`endif
        check("b_ovf", b.out_ovf, 1);
        check("b_fire_never", b.out_fire, 0);

        // async reset mid-window
        send_a(6'd32, 1'b0);
        send_a(6'd32, 1'b0);
        send_a(6'd32, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sum", a.out_sum, 0);
        check("arst_in_ready", a.in_ready, 1);
        check("arst_valid", a.out_valid, 0);
        check("arst_b_valid", b.out_valid, 0);
        check("arst_b_ovf", b.out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_a(6'd7, 1'b1);
        check("post_rst_sum", a.out_sum, 7);
        check("post_rst_valid", a.out_valid, 1);
        release_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
